// File: rtl/jk_cmd_pkg.sv
// Shared command-bit layout, command word type and sequencer FSM encoding.
// No logic; no latency.
// No flow control.
package jk_cmd_pkg;

    localparam int CMD_SET = 3;
    localparam int CMD_RST = 2;
    localparam int CMD_J   = 1;
    localparam int CMD_K   = 0;

    typedef logic [3:0] cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Synchronises one raw button, debounces it and emits a one-cycle press pulse on each debounced rise.
// Latency: 2 sync + DEBOUNCE_CYCLES cycles from raw edge to press.
// No backpressure: the press pulse is always produced.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            press <= 1'b0;
            // Any sample matching the current level breaks the run and restarts the count.
            if (sync2 != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync2;
                    cnt   <= '0;
                    press <= sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Turns four raw buttons into queued, fixed-length set/reset/J/K frames for a negedge JK stage.
// Latency: DEBOUNCE_CYCLES+4 cycles from raw rise to frame start when idle; frame period HOLD_CYCLES+1.
// Commands arriving on a full queue are dropped and flagged by sticky overflow.
module jk_cmd_sequencer
    import jk_cmd_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int FIFO_DEPTH      = 4,
    parameter int HOLD_CYCLES     = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          btn_j,
    input  logic                          btn_k,
    input  logic                          btn_set,
    input  logic                          btn_rst,
    input  logic                          clr_ovf,
    output logic                          jk_set,
    output logic                          jk_reset,
    output logic                          jk_j,
    output logic                          jk_k,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    logic p_set, p_rst, p_j, p_k;
    cmd_t cmd;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (.clk(clk), .reset(reset), .raw(btn_set), .press(p_set));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (.clk(clk), .reset(reset), .raw(btn_rst), .press(p_rst));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_j   (.clk(clk), .reset(reset), .raw(btn_j),   .press(p_j));
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_k   (.clk(clk), .reset(reset), .raw(btn_k),   .press(p_k));

    // Presses landing in the same cycle merge into one queue entry.
    assign cmd = {p_set, p_rst, p_j, p_k};

    cmd_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          pop;
    logic          push;
    logic          drop;

    assign push = (cmd != '0) && ((count < CW'(FIFO_DEPTH)) || pop);
    assign drop = (cmd != '0) && !push;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            // A drop in the same cycle as a clear wins so no loss goes unreported.
            if (drop)         overflow <= 1'b1;
            else if (clr_ovf) overflow <= 1'b0;
        end
    end

    state_t        state, state_n;
    logic [HW-1:0] hold_cnt, hold_cnt_n;
    cmd_t          out_q, out_n;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
            out_q    <= '0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_cnt_n;
            out_q    <= out_n;
        end
    end

    always_comb begin
        state_n    = state;
        hold_cnt_n = hold_cnt;
        out_n      = out_q;
        pop        = 1'b0;
        unique case (state)
            IDLE, GAP: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    out_n      = mem[rd_ptr];
                    hold_cnt_n = '0;
                    state_n    = DRIVE;
                end else begin
                    out_n   = '0;
                    state_n = IDLE;
                end
            end
            DRIVE: begin
                if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
                    out_n   = '0;
                    state_n = GAP;
                end else begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
            end
            default: begin
                out_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign jk_set     = out_q[CMD_SET];
    assign jk_reset   = out_q[CMD_RST];
    assign jk_j       = out_q[CMD_J];
    assign jk_k       = out_q[CMD_K];
    assign busy       = (state != IDLE);
    assign fifo_count = count;

endmodule
